// File: rtl/fifo_spi_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter.
// Holds the data width, default FIFO depth and bit period, and the
// serializer state encoding used by fifo_spi.
package fifo_spi_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_BIT_CYCLES = 2;

    // Serializer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/fifo_spi_fifo.sv
// Synchronous show-ahead FIFO of DATA_W-bit words.
// Ports: clk, nrst (async active-low), push/din (write side),
//        pop (read side), dout (oldest word, valid when !empty),
//        empty, full, count (0..DEPTH).
module fifo_spi_fifo
    import fifo_spi_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               din,
    output logic [DATA_W-1:0]               dout,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fifo_spi.sv
// FIFO-buffered serial transmitter. Words written with we/din are queued
// and sent on dout as: start bit (0), 32 data bits MSB first, stop bit (1),
// each bit held BIT_CYCLES clocks. dout idles high.
// Ports: clk, nrst (async active-low), we, din[31:0], dout (registered).
module fifo_spi
    import fifo_spi_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic              dout
);

    localparam int unsigned CNT_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W  = $clog2(DATA_W);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              dout_nxt;
    logic              pop_c;
    logic              last_cnt;

    logic [DATA_W-1:0] fifo_word;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FCNT_W-1:0] fifo_count;
    logic              unused_c;

    fifo_spi_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (we),
        .pop   (pop_c),
        .din   (din),
        .dout  (fifo_word),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // FIFO status beyond empty is not needed by the serializer.
    assign unused_c = ^{fifo_full, fifo_count};

    assign last_cnt = (bit_cnt == CNT_W'(BIT_CYCLES - 1));

    // State and serializer registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            dout    <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            dout    <= dout_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        dout_nxt    = dout;
        pop_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                dout_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    shreg_nxt   = fifo_word;
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_START;
                    dout_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (last_cnt) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_DATA;
                    dout_nxt    = shreg[DATA_W-1];
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (last_cnt) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        state_nxt = ST_STOP;
                        dout_nxt  = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
                        dout_nxt    = shreg[DATA_W-2];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: begin // ST_STOP
                if (last_cnt) begin
                    bit_cnt_nxt = '0;
                    // Chain straight into the next frame so frames are
                    // separated by exactly one stop bit.
                    if (!fifo_empty) begin
                        pop_c     = 1'b1;
                        shreg_nxt = fifo_word;
                        state_nxt = ST_START;
                        dout_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        dout_nxt  = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_spi.sv
// Self-checking bench for fifo_spi: queue-level reference model predicts
// which words are accepted and at which edge each frame starts; a serial
// monitor decodes dout and checks against the expected-frame queue.
module tb_fifo_spi;

    localparam int DEPTH = 16;
    localparam int BC    = 2;
    localparam int FRAME = 34 * BC;

    logic        clk;
    logic        nrst;
    logic        we;
    logic [31:0] din;
    logic        dout;

    fifo_spi #(
        .DEPTH      (DEPTH),
        .BIT_CYCLES (BC)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .we   (we),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          edge_n;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int          edge_n    = 0;
    int          free_edge = 0;
    int          n_cmp     = 0;
    int          n_err     = 0;
    int          frames    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Reference model: the transmitter takes the oldest word whenever it is
    // free and the queue held something before this edge; a frame occupies it
    // for FRAME cycles. Writes are dropped when the queue was full before the edge.
    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        free_edge = 0;
    endtask

    task automatic model_step();
        bit   was_full;
        exp_t e;
        was_full = (mq.size() == DEPTH);
        if (mq.size() > 0 && edge_n >= free_edge) begin
            e.word   = mq.pop_front();
            e.edge_n = edge_n;
            exp_q.push_back(e);
            free_edge = edge_n + FRAME;
        end
        if (we && !was_full) mq.push_back(din);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!nrst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input logic [31:0] d);
        we  = 1'b1;
        din = d;
        tick();
        we  = 1'b0;
    endtask

    // Serial monitor
    bit          in_frame = 1'b0;
    bit          have_exp;
    bit          held;
    logic        lvl;
    int          pos;
    int          smp;
    logic [31:0] acc;
    logic [31:0] cur;

    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            in_frame = 1'b0;
            chk("reset_dout", {31'd0, dout}, 32'd1);
        end else begin
            if (!in_frame) begin
                if (dout === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0;
                    smp = 0;
                    acc = '0;
                    if (exp_q.size() == 0) begin
                        have_exp = 1'b0;
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: start bit at edge %0d, required no frame", edge_n);
                    end else begin
                        e = exp_q.pop_front();
                        have_exp = 1'b1;
                        cur = e.word;
                        chk("start_edge", edge_n, e.edge_n);
                    end
                end else begin
                    chk("idle_dout", {31'd0, dout}, 32'd1);
                end
            end
            if (in_frame) begin
                if (smp == 0) begin
                    lvl  = dout;
                    held = 1'b1;
                end else if (dout !== lvl) begin
                    held = 1'b0;
                end
                if (smp == BC - 1) begin
                    chk($sformatf("bit_hold[%0d]", pos), {31'd0, held}, 32'd1);
                    if (pos == 0) begin
                        chk("start_level", {31'd0, lvl}, 32'd0);
                    end else if (pos <= 32) begin
                        acc = {acc[30:0], lvl};
                    end else begin
                        chk("stop_level", {31'd0, lvl}, 32'd1);
                        if (have_exp) chk("frame_word", acc, cur);
                        frames++;
                        in_frame = 1'b0;
                    end
                    pos++;
                    smp = 0;
                end else begin
                    smp++;
                end
            end
        end
    end

    initial begin
        int f0;
        int waited;
        int burst_left;

        nrst = 1'b0;
        we   = 1'b0;
        din  = '0;

        // Reset held 10 cycles, then 10 idle cycles
        idle(10);
        nrst = 1'b1;
        idle(10);
        chk("idle_after_reset", {31'd0, dout}, 32'd1);

        // Single word
        f0 = frames;
        put(32'hA5A5A5A5);
        idle(FRAME + 20);
        chk("frames_single", frames - f0, 1);

        // Spaced burst of 254 words
        f0 = frames;
        for (int n = 0; n < 254; n++) begin
            put({4{8'(n)}});
            idle(250);
        end
        chk("frames_burst", frames - f0, 254);

        // Overflow: 20 back-to-back writes
        f0 = frames;
        we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 32'(i);
            tick();
        end
        we = 1'b0;
        idle(18 * FRAME + 50);
        chk("frames_overflow", frames - f0, 17);

        // Mid-frame reset during data bit 10
        f0 = frames;
        put(32'h0000_0000);
        waited = 0;
        while (!(in_frame && pos == 11) && waited < 400) begin
            tick();
            waited++;
        end
        chk("reach_bit10", {31'd0, waited < 400}, 32'd1);
        #2;
        chk("pre_reset_dout", {31'd0, dout}, 32'd0);
        nrst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_dout", {31'd0, dout}, 32'd1);
        idle(3);
        nrst = 1'b1;
        idle(200);
        chk("no_frame_after_reset", frames - f0, 0);
        put(32'h1234_5678);
        idle(FRAME + 20);
        chk("frame_after_reset", frames - f0, 1);

        // Pointer wrap: 3*DEPTH words, one per 80 cycles
        f0 = frames;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            put($urandom);
            idle(79);
        end
        idle(FRAME);
        chk("frames_wrap", frames - f0, 3 * DEPTH);

        // Random traffic with occasional bursts that may overflow
        burst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst_left == 0 && $urandom_range(0, 299) == 0)
                burst_left = $urandom_range(5, 25);
            we  = (burst_left > 0) || ($urandom_range(0, 49) == 0);
            din = $urandom;
            if (burst_left > 0) burst_left--;
            tick();
        end
        we = 1'b0;

        // Drain
        idle((DEPTH + 2) * FRAME);
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_in_frame", {31'd0, in_frame}, 32'd0);
        chk("drain_dout", {31'd0, dout}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_spi.md
FIFO_SPI -- requirements
Module: fifo_spi

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in 32-bit words (power of two, >=2).
REQ-002 Parameter BIT_CYCLES, default 2, clk cycles each serial bit is held (>=1).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 we  input  1  write strobe; one word accepted per clk cycle where we=1.
REQ-006 din  input  32  write data, sampled on rising clk when we=1.
REQ-007 dout  output  1  registered serial data output; idle level 1.

Function
REQ-008 Write: rising clk with we=1 and FIFO not full SHALL store din at the write pointer and increment the write pointer and word count.
REQ-009 Write with FIFO full (count==DEPTH) SHALL be discarded with no state change, even if a pop occurs in the same cycle.
REQ-010 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL range 0..DEPTH.
REQ-011 Serializer states: IDLE, START, DATA, STOP.
REQ-012 IDLE: dout=1; if FIFO non-empty at a rising clk, the serializer SHALL pop the oldest word into a 32-bit shift register, enter START, and drive dout=0 from that edge.
REQ-013 Pop and write in the same cycle SHALL both take effect (count unchanged) when not full.
REQ-014 A word written at rising edge k into an empty FIFO with serializer idle SHALL produce dout=0 (start bit) after edge k+1.
REQ-015 START SHALL last BIT_CYCLES cycles, then DATA.
REQ-016 DATA SHALL output 32 bits MSB first (din[31] first), each held exactly BIT_CYCLES cycles.
REQ-017 STOP SHALL drive dout=1 for BIT_CYCLES cycles, then return to IDLE; back-to-back words SHALL be separated by exactly one stop bit.
REQ-018 Frame length SHALL be 34*BIT_CYCLES cycles (68 at default); the FIFO SHALL NOT pop during a frame.
REQ-019 Words SHALL leave in strict write order; no word duplicated or skipped except those dropped per REQ-009.
REQ-020 Bit timing SHALL use a counter 0..BIT_CYCLES-1 and a bit index 0..31; no derived or gated clocks.

Reset
REQ-021 nrst=0 SHALL immediately (asynchronously) clear pointers and count, force IDLE, clear shift register and counters, and set dout=1.
REQ-022 Reset mid-frame SHALL abort the frame; FIFO contents are discarded.
REQ-023 After nrst deasserts, the first rising clk SHALL operate normally.
REQ-024 FIFO storage array need not be reset.

Structure
REQ-025 Package fifo_spi_pkg SHALL hold DATA_W=32, default DEPTH and BIT_CYCLES, and the serializer state enumeration.
REQ-026 Synchronous FIFO SHALL be a sub-module fifo_spi_fifo (push, pop, din, dout, empty, full, count); serializer FSM resides in fifo_spi.

Verification
REQ-027 Reset: nrst=0 for 10 cycles -> dout=1 throughout and for 10 cycles after release with we=0.
REQ-028 Single word: we=1 one cycle, din=0xA5A5A5A5 -> start bit after edge k+1, bits 1,0,1,0,0,1,0,1,... each 2 cycles, stop bit, then dout=1.
REQ-029 Burst: 254 writes of {4{n}}, n=0..253, spaced 251 cycles -> each frame decodes to 0x00000000, 0x01010101, ... 0xFDFDFDFD in order, no overflow.
REQ-030 Overflow: 20 consecutive writes 0..19 with DEPTH=16 -> 17 frames (0..16: one popped at start, 16 stored), writes 17..19 dropped; frames back-to-back with 1 stop bit.
REQ-031 Mid-frame reset: nrst=0 during DATA bit 10 -> dout=1 immediately; after release no frame emitted until new write.
REQ-032 Pointer wrap: 3*DEPTH writes at 1 per 80 cycles -> all 48 words emitted correctly and in order.
